// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Desc     : Shared state encoding and BCD time types for the stopwatch core.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int c_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    typedef struct packed {
        logic [c_DIGIT_W-1:0] min_tens;
        logic [c_DIGIT_W-1:0] min_ones;
        logic [c_DIGIT_W-1:0] sec_tens;
        logic [c_DIGIT_W-1:0] sec_ones;
    } bcd_time_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Desc     : Single BCD counter digit wrapping at MAX_VAL with carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX_VAL = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [c_DIGIT_W-1:0] q,
    output logic                 carry
);

    localparam logic [c_DIGIT_W-1:0] c_MAX  = c_DIGIT_W'(MAX_VAL);
    localparam logic [c_DIGIT_W-1:0] c_ZERO = '0;
    localparam logic [c_DIGIT_W-1:0] c_ONE  = c_DIGIT_W'(1);

    logic [c_DIGIT_W-1:0] r_q;

    // Wrapping on >= keeps the digit legal even if it ever held an out-of-range value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= c_ZERO;
        end else if (inc) begin
            r_q <= (r_q >= c_MAX) ? c_ZERO : r_q + c_ONE;
        end
    end

    assign q     = r_q;
    assign carry = inc & (r_q == c_MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_core
// Desc     : MM:SS BCD stopwatch with run/pause FSM, lap freeze and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_en,
    input  logic                 start_stop,
    input  logic                 clear,
    input  logic                 lap,
    output logic [c_DIGIT_W-1:0] sec_ones,
    output logic [c_DIGIT_W-1:0] sec_tens,
    output logic [c_DIGIT_W-1:0] min_ones,
    output logic [c_DIGIT_W-1:0] min_tens,
    output logic                 running,
    output logic                 lap_active,
    output logic                 overflow
);

    localparam logic [c_DIGIT_W-1:0] c_MAX_MIN_TENS = c_DIGIT_W'(MAX_MINUTES / 10);
    localparam logic [c_DIGIT_W-1:0] c_MAX_MIN_ONES = c_DIGIT_W'(MAX_MINUTES % 10);

    state_t    r_state;
    state_t    w_state_next;
    bcd_time_t r_snap;
    logic      r_lap_active;
    logic      r_overflow;

    logic [c_DIGIT_W-1:0] w_sec_ones;
    logic [c_DIGIT_W-1:0] w_sec_tens;
    logic [c_DIGIT_W-1:0] w_min_ones;
    logic [c_DIGIT_W-1:0] w_min_tens;
    logic      w_sec_ones_carry;
    logic      w_sec_tens_carry;
    logic      w_min_ones_carry;
    logic      w_min_tens_carry;
    logic      w_tick;
    logic      w_min_at_max;
    logic      w_min_wrap;
    logic      w_min_clr;
    bcd_time_t w_live;
    bcd_time_t w_disp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Gated on the current state, so the RUN->PAUSE cycle still counts and IDLE->RUN does not.
    assign w_tick = tick_en & (r_state == RUN) & ~clear;

    bcd_digit #(.MAX_VAL(9)) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_tick),
        .clr   (clear),
        .q     (w_sec_ones),
        .carry (w_sec_ones_carry)
    );

    bcd_digit #(.MAX_VAL(5)) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sec_ones_carry),
        .clr   (clear),
        .q     (w_sec_tens),
        .carry (w_sec_tens_carry)
    );

    // Minutes terminate at MAX_MINUTES rather than at 99.
    assign w_min_at_max = (w_min_tens == c_MAX_MIN_TENS) && (w_min_ones == c_MAX_MIN_ONES);
    assign w_min_wrap   = w_sec_tens_carry & (w_min_at_max | w_min_tens_carry);
    assign w_min_clr    = clear | w_min_wrap;

    bcd_digit #(.MAX_VAL(9)) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sec_tens_carry),
        .clr   (w_min_clr),
        .q     (w_min_ones),
        .carry (w_min_ones_carry)
    );

    bcd_digit #(.MAX_VAL(9)) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_min_ones_carry),
        .clr   (w_min_clr),
        .q     (w_min_tens),
        .carry (w_min_tens_carry)
    );

    assign w_live = {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones};

    // Snapshot takes the registered live value, i.e. the pre-tick time on a coincident tick.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_snap       <= '0;
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (r_lap_active && (r_state == RUN || r_state == PAUSE)) begin
                r_lap_active <= 1'b0;
            end else if (!r_lap_active && r_state == RUN) begin
                r_snap       <= w_live;
                r_lap_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_overflow <= 1'b0;
        end else if (w_min_wrap) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_disp     = r_lap_active ? r_snap : w_live;
    assign sec_ones   = w_disp.sec_ones;
    assign sec_tens   = w_disp.sec_tens;
    assign min_ones   = w_disp.min_ones;
    assign min_tens   = w_disp.min_tens;
    assign running    = (r_state == RUN);
    assign lap_active = r_lap_active;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_core
// Desc     : Scoreboard bench for stopwatch_core (MAX_MINUTES=59 and =1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [18:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst, tick_en, start_stop, clear, lap;
    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic run0, lap0, ovf0, run1, lap1, ovf1;
    logic [18:0] act0, act1;

    int   cycle_count = 0;
    int   checks      = 0;
    int   failures    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    stopwatch_core dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .lap_active(lap0), .overflow(ovf0)
    );

    stopwatch_core #(.MAX_MINUTES(1)) dut1 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .lap_active(lap1), .overflow(ovf1)
    );

    assign act0 = {mt0, mo0, st0, so0, run0, lap0, ovf0};
    assign act1 = {mt1, mo1, st1, so1, run1, lap1, ovf1};

    function automatic logic [18:0] ev(int m, int s, logic r, logic l, logic o);
        logic [15:0] d;
        d = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return {d, r, l, o};
    endfunction

    // Monitor: pops every expectation due at this cycle and compares.
    always @(negedge clk) begin
        exp_t        e;
        logic [18:0] a;
        while (sb.size() != 0 && sb[0].cyc <= cycle_count) begin
            e = sb.pop_front();
            a = e.sel ? act1 : act0;
            checks++;
            if (e.cyc != cycle_count || a !== e.val) begin
                failures++;
                $display("FAIL %s (dut%0d): got %h want %h", e.name, e.sel, a, e.val);
            end
        end
    end

    task automatic expect_out(string nm, bit sel, logic [18:0] v);
        exp_t e;
        e.cyc  = cycle_count + 1;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(logic r, logic tk, logic ss, logic cl, logic lp);
        rst = r; tick_en = tk; start_stop = ss; clear = cl; lap = lp;
        @(negedge clk);
        rst = 1'b0; tick_en = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic tick_check(int n, string nm, bit sel, logic [18:0] v);
        repeat (n - 1) step(0, 1, 0, 0, 0);
        expect_out(nm, sel, v);
        step(0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        @(negedge clk);

        expect_out("reset", 0, ev(0, 0, 0, 0, 0));
        expect_out("reset", 1, ev(0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0);

        // Basic run, carries and RUN->PAUSE tick
        expect_out("start", 0, ev(0, 0, 1, 0, 0));           step(0, 0, 1, 0, 0);
        tick_check(3,  "three_ticks", 0, ev(0, 3, 1, 0, 0));
        tick_check(56, "to_0059",     0, ev(0, 59, 1, 0, 0));
        tick_check(1,  "to_0100",     0, ev(1, 0, 1, 0, 0));
        expect_out("ss_tick", 0, ev(1, 1, 0, 0, 0));         step(0, 1, 1, 0, 0);
        tick_check(3,  "pause_hold",  0, ev(1, 1, 0, 0, 0));
        expect_out("pause_lap_ign", 0, ev(1, 1, 0, 0, 0));   step(0, 0, 0, 0, 1);
        expect_out("resume", 0, ev(1, 1, 1, 0, 0));          step(0, 0, 1, 0, 0);
        expect_out("clear", 0, ev(0, 0, 0, 0, 0));           step(0, 0, 0, 1, 0);
        expect_out("idle_tick", 0, ev(0, 0, 0, 0, 0));       step(0, 1, 0, 0, 0);
        expect_out("start_tick", 0, ev(0, 0, 1, 0, 0));      step(0, 1, 1, 0, 0);

        // Lap freeze
        tick_check(5, "to_0005", 0, ev(0, 5, 1, 0, 0));
        expect_out("lap_on", 0, ev(0, 5, 1, 1, 0));          step(0, 0, 0, 0, 1);
        tick_check(3, "frozen", 0, ev(0, 5, 1, 1, 0));
        expect_out("lap_off", 0, ev(0, 8, 1, 0, 0));         step(0, 0, 0, 0, 1);
        expect_out("lap_tick", 0, ev(0, 8, 1, 1, 0));        step(0, 1, 0, 0, 1);
        tick_check(1, "frozen2", 0, ev(0, 8, 1, 1, 0));
        expect_out("lap_off2", 0, ev(0, 10, 1, 0, 0));       step(0, 0, 0, 0, 1);
        expect_out("lap_on2", 0, ev(0, 10, 1, 1, 0));        step(0, 0, 0, 0, 1);
        expect_out("pause_frozen", 0, ev(0, 10, 0, 1, 0));   step(0, 0, 1, 0, 0);
        tick_check(1, "pause_frz_tick", 0, ev(0, 10, 0, 1, 0));
        expect_out("pause_lap_off", 0, ev(0, 10, 0, 0, 0));  step(0, 0, 0, 0, 1);
        expect_out("resume2", 0, ev(0, 10, 1, 0, 0));        step(0, 0, 1, 0, 0);
        expect_out("lap_on3", 0, ev(0, 10, 1, 1, 0));        step(0, 0, 0, 0, 1);
        tick_check(2, "frozen3", 0, ev(0, 10, 1, 1, 0));

        // Reset while running and frozen
        expect_out("rst_mid", 0, ev(0, 0, 0, 0, 0));
        expect_out("rst_mid", 1, ev(0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0);
        expect_out("post_rst_idle", 0, ev(0, 0, 0, 0, 0));   step(0, 1, 0, 0, 0);

        // Clear beats start_stop, lap and tick
        expect_out("start3", 0, ev(0, 0, 1, 0, 0));          step(0, 0, 1, 0, 0);
        tick_check(2, "to_0002", 0, ev(0, 2, 1, 0, 0));
        expect_out("clear_prio", 0, ev(0, 0, 0, 0, 0));      step(0, 1, 1, 1, 1);

        // MAX_MINUTES=1 wrap and sticky overflow
        expect_out("start4", 1, ev(0, 0, 1, 0, 0));          step(0, 0, 1, 0, 0);
        tick_check(119, "m1_0159", 1, ev(1, 59, 1, 0, 0));
        expect_out("m1_wrap", 1, ev(0, 0, 1, 0, 1));
        expect_out("m59_nowrap", 0, ev(2, 0, 1, 0, 0));
        step(0, 1, 0, 0, 0);
        tick_check(2, "m1_sticky", 1, ev(0, 2, 1, 0, 1));
        expect_out("m1_clear", 1, ev(0, 0, 0, 0, 0));        step(0, 0, 0, 1, 0);

        // Default MAX_MINUTES=59 wrap
        expect_out("start5", 0, ev(0, 0, 1, 0, 0));          step(0, 0, 1, 0, 0);
        tick_check(3599, "m59_5959", 0, ev(59, 59, 1, 0, 0));
        expect_out("m59_wrap", 0, ev(0, 0, 1, 0, 1));        step(0, 1, 0, 0, 0);
        expect_out("final_clear", 0, ev(0, 0, 0, 0, 0));
        expect_out("final_clear", 1, ev(0, 0, 0, 0, 0));
        step(0, 0, 0, 1, 0);

        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
